// File: rtl/uart_loader_pkg.sv
// -----------------------------------------------------------------------------
// uart_loader_pkg
// Shared definitions for the UART program loader:
//   - state_t        : loader FSM state encoding (LOAD, CHECK, RUN, ERROR)
//   - WORD_W         : instruction word width in bits
//   - BYTES_PER_WORD : UART bytes packed into one instruction word
//   - DEFAULT_CELL_NUMBERS : default number of words loaded at boot
// CHECK and ERROR are only reachable when UART_LOADER_CHECKSUM_EN is defined.
// -----------------------------------------------------------------------------
package uart_loader_pkg;

   localparam int WORD_W               = 32;
   localparam int BYTES_PER_WORD       = 4;
   localparam int BYTE_CNT_W           = $clog2(BYTES_PER_WORD);
   localparam int DEFAULT_CELL_NUMBERS = 64;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_CHECK = 2'd1,
      ST_RUN   = 2'd2,
      ST_ERROR = 2'd3
   } state_t;

endpackage

// File: rtl/uart_word_packer.sv
// -----------------------------------------------------------------------------
// uart_word_packer
// Collects UART bytes into a 32-bit little-endian word. The first byte of a
// word lands in [7:0], the fourth in [31:24]. When the fourth byte is
// presented, o_word_valid is high for that cycle and o_word carries the full
// word (the incoming byte bypasses the lane register into the top lane).
// Ports:
//   clk          in   system clock
//   i_clr        in   synchronous clear, discards any partial word
//   i_valid      in   accept i_data this cycle
//   i_data       in   8-bit byte
//   o_word_valid out  complete word available this cycle
//   o_word       out  assembled word, meaningful while o_word_valid is high
// -----------------------------------------------------------------------------
module uart_word_packer
   import uart_loader_pkg::*;
(
   input  logic              clk,
   input  logic              i_clr,
   input  logic              i_valid,
   input  logic [7:0]        i_data,
   output logic              o_word_valid,
   output logic [WORD_W-1:0] o_word
);

   logic [BYTE_CNT_W-1:0] r_byte_cnt;
   logic [WORD_W-1:0]     r_word;
   logic                  w_last_byte;

   assign w_last_byte  = (r_byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));
   assign o_word_valid = i_valid && w_last_byte;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (i_clr) begin
         r_byte_cnt <= '0;
         r_word     <= '0;
      end else if (i_valid) begin
         r_word[r_byte_cnt*8 +: 8] <= i_data;
         // Power-of-two byte count, so the natural overflow gives the 3->0 wrap.
         r_byte_cnt <= r_byte_cnt + 1'b1;
      end
   end

   always_comb begin
      o_word                = r_word;
      o_word[WORD_W-1 -: 8] = i_data;
   end

endmodule

// File: rtl/uart_prog_loader.sv
// -----------------------------------------------------------------------------
// uart_prog_loader
// Boot-time loader between the UART receiver and instruction memory. Packs
// bytes into words, writes CELL_NUMBERS words to addresses 0.. upward, holds
// the CPU stalled while loading and releases it after the last write.
// Optional feature macro: UART_LOADER_CHECKSUM_EN -- after the last word one
// extra byte must equal the XOR of all loaded bytes, otherwise the loader
// parks in ERROR with load_err high and the CPU stalled until rst.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   rx_data    in   received UART byte
//   rx_valid   in   one-cycle strobe for rx_data
//   imem_we    out  one-cycle write pulse per word
//   imem_addr  out  word address of the current write
//   imem_wdata out  assembled instruction word (holds between writes)
//   cpu_stall  out  high keeps the CPU frozen
//   load_done  out  high once the CPU is running
//   load_err   out  checksum failure (constant 0 without the feature)
// -----------------------------------------------------------------------------
module uart_prog_loader
   import uart_loader_pkg::*;
#(
   parameter int CELL_NUMBERS = DEFAULT_CELL_NUMBERS,
   parameter int ADDR_W       = 6
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [WORD_W-1:0] imem_wdata,
   output logic              cpu_stall,
   output logic              load_done,
   output logic              load_err
);

   localparam int               CNT_W     = (CELL_NUMBERS > 1) ? $clog2(CELL_NUMBERS) : 1;
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(CELL_NUMBERS - 1);

   state_t              r_state;
   state_t              w_state_next;
   logic [CNT_W-1:0]    r_word_cnt;
   logic                r_last_wr;
   logic                w_accept;
   logic                w_word_valid;
   logic [WORD_W-1:0]   w_word;

   // r_last_wr marks the cycle of the final write pulse; bytes arriving then
   // belong to nothing and are dropped along with everything after the load.
   assign w_accept = rx_valid && (r_state == ST_LOAD) && !r_last_wr;

   uart_word_packer u_packer (
      .clk          (clk),
      .i_clr        (rst),
      .i_valid      (w_accept),
      .i_data       (rx_data),
      .o_word_valid (w_word_valid),
      .o_word       (w_word)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_word_cnt <= '0;
         r_last_wr  <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
      end else begin
         imem_we   <= w_word_valid;
         r_last_wr <= w_word_valid && (r_word_cnt == LAST_WORD);
         if (w_word_valid) begin
            imem_addr  <= ADDR_W'(r_word_cnt);
            imem_wdata <= w_word;
            // Saturate on the last word so the counter stays inside the image.
            if (r_word_cnt != LAST_WORD) begin
               r_word_cnt <= r_word_cnt + 1'b1;
            end
         end
      end
   end

`ifdef UART_LOADER_CHECKSUM_EN
   logic [7:0] r_xor;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_xor <= '0;
      end else if (w_accept) begin
         r_xor <= r_xor ^ rx_data;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_LOAD;
      end else begin
         r_state <= w_state_next;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      w_state_next = r_state;
      cpu_stall    = (r_state != ST_RUN);
      load_done    = (r_state == ST_RUN);
`ifdef UART_LOADER_CHECKSUM_EN
      load_err     = (r_state == ST_ERROR);
`else
      load_err     = 1'b0;
`endif
      case (r_state)
         ST_LOAD: begin
            if (r_last_wr) begin
`ifdef UART_LOADER_CHECKSUM_EN
               w_state_next = ST_CHECK;
`else
               w_state_next = ST_RUN;
`endif
            end
         end
`ifdef UART_LOADER_CHECKSUM_EN
         ST_CHECK: begin
            if (rx_valid) begin
               w_state_next = (rx_data == r_xor) ? ST_RUN : ST_ERROR;
            end
         end
`endif
         default: begin
            // RUN and ERROR are terminal until rst.
         end
      endcase
   end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Boot-time controller between the UART receiver and the CPU's instruction memory.
- Packs incoming bytes into 32-bit little-endian words and writes exactly CELL_NUMBERS words to consecutive instruction-memory addresses from 0.
- Holds the CPU stalled during loading and releases it once the last word is written.
- Sequences the CPU's load phase and execute phase from a single FSM.

Parameters:
- CELL_NUMBERS, 64, number of 32-bit instruction words to load (must be ≥1).
- ADDR_W, 6, instruction-memory word-address width (≥ clog2(CELL_NUMBERS)).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_data  input  8  received UART byte.
- rx_valid  input  1  one-cycle strobe, rx_data valid this cycle.
- imem_we  output  1  instruction-memory write enable, one-cycle pulse per word.
- imem_addr  output  ADDR_W  word address for the current write.
- imem_wdata  output  32  assembled instruction word.
- cpu_stall  output  1  high holds the CPU (PC frozen, no register-file writes).
- load_done  output  1  high once all words are written and the CPU is running.
- load_err  output  1  checksum failure, only with the optional feature.

Behaviour:
- Reset values:
  - state=LOAD, byte_cnt=0, word_cnt=0.
  - imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_stall=1, load_done=0, load_err=0.
- Reset has priority over every other event, including an rx_valid in the same cycle.
- rst asserted mid-load discards any partial word and restarts addressing at 0.
- States:
  - LOAD: byte collection active.
  - CHECK: present only with the optional feature.
  - RUN: CPU released.
  - ERROR: present only with the optional feature.
- Byte packing in LOAD:
  - Each rx_valid byte is written into lane byte_cnt: byte 0 → [7:0], byte 3 → [31:24].
  - byte_cnt then increments and wraps 3→0.
  - With rx_valid low, byte_cnt and the partial word hold.
- Write timing:
  - The 4th byte is accepted at edge N.
  - Cycle after N: imem_we=1, imem_addr=word_cnt, imem_wdata=the full word.
  - word_cnt increments at the same edge that raises imem_we.
  - imem_we is high for exactly one cycle.
- Throughput:
  - Bytes are accepted every cycle, including cycles where imem_we is high.
  - Sustained rate is 1 word per 4 cycles, with no back-pressure.
- Last word (word_cnt == CELL_NUMBERS-1 when its 4th byte arrives):
  - Its write pulse occurs normally.
  - Without the feature, the FSM moves to RUN at the edge ending that pulse.
  - cpu_stall falls and load_done rises in the cycle right after the last imem_we.
- RUN:
  - rx_valid is ignored, with no writes and no counter changes.
  - The FSM stays in RUN until rst.
- Address width: imem_addr = word_cnt truncated to ADDR_W. word_cnt never exceeds CELL_NUMBERS-1, so there is no wrap inside the load.
- imem_wdata holds its last value when imem_we=0. Its value is don't-care for verification except during imem_we.

Optional Feature:
- Macro: UART_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of all loaded bytes is kept.
  - After the last word the FSM enters CHECK and waits for one extra rx_valid byte.
  - Byte equals the XOR → RUN next edge, with the same output changes as above.
  - Byte differs → ERROR: load_err=1, cpu_stall stays 1, load_done=0, rx ignored until rst.
- Undefined:
  - No CHECK or ERROR states and no XOR register.
  - load_err is tied to 0.

Decomposition:
- Package uart_loader_pkg:
  - State encoding (LOAD, CHECK, RUN, ERROR).
  - WORD_W=32, BYTES_PER_WORD=4.
  - Default CELL_NUMBERS.
- One sub-module, uart_word_packer: byte_cnt plus the 32-bit shift/lane register.
  - Emits word_valid and word for one cycle.
  - Has its own synchronous clear, driven by rst.
- The top holds the FSM, word_cnt, output registers and the optional XOR.

Test Plan:
1. Reset, then bytes FE,FF,FF,FF on consecutive cycles → one imem_we pulse, imem_addr=0, imem_wdata=0xFFFF_FFFE (encodes -2), cpu_stall still 1.
2. CELL_NUMBERS=4, 16 back-to-back bytes 00..0F → pulses at addresses 0..3 with data 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C. cpu_stall=0 and load_done=1 exactly one cycle after the 4th pulse.
3. Bytes separated by random 0–5 idle cycles → identical memory contents to test 2, no spurious imem_we.
4. rst for one cycle after 6 bytes, then 4 new bytes AA,BB,CC,DD → single write at addr 0 with data 0xDDCCBBAA.
5. After RUN, 8 more rx_valid bytes → no imem_we, imem_addr and load_done unchanged.
6. With UART_LOADER_CHECKSUM_EN and CELL_NUMBERS=1, bytes 01,02,04,08:
   - Checksum 0x0F → RUN.
   - Repeat with checksum 0x0E → load_err=1, cpu_stall=1, load_done=0 until rst.
